// File: rtl/seq_pkg.sv
// seq_pkg: shared types and constants for the layer sequencer.
//   seq_state_t : sequencer FSM states
//   RAM0/RAM1   : ping-pong activation RAM indices
//   rd_buf(k)   : RAM read by layer k (the other RAM is written)
package seq_pkg;

    localparam int LAYER_W = 3;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        LAUNCH,
        RUN,
        ADVANCE,
        FINISH
    } seq_state_t;

    localparam logic RAM0 = 1'b0;
    localparam logic RAM1 = 1'b1;

    function automatic logic rd_buf(input logic [LAYER_W-1:0] k);
        return k[0];
    endfunction

endpackage

// File: rtl/seq_ram_router.sv
// seq_ram_router: combinational routing of the two ping-pong activation RAMs.
//   cur_layer, busy      : active layer index and sequencer-busy flag
//   layer_*              : flattened layer engine buses (layer k at [k*W +: W])
//   layer_inp_data       : read data of the active layer's read RAM
//   ram_addr/wdata/we    : RAM0 in the low slice, RAM1 in the high slice
//   ram_q                : registered read data from RAM0/RAM1
//   host_*               : host port, owns RAM host_buf while idle
module seq_ram_router
    import seq_pkg::*;
#(
    parameter int NUM_LAYERS = 4,
    parameter int ADDR_W     = 11,
    parameter int DATA_W     = 16
) (
    input  logic [LAYER_W-1:0]           cur_layer,
    input  logic                         busy,
    input  logic [NUM_LAYERS*ADDR_W-1:0] layer_inp_addr,
    input  logic [NUM_LAYERS*ADDR_W-1:0] layer_out_addr,
    input  logic [NUM_LAYERS*DATA_W-1:0] layer_out_data,
    input  logic [NUM_LAYERS-1:0]        layer_out_we,
    output logic [DATA_W-1:0]            layer_inp_data,
    output logic [2*ADDR_W-1:0]          ram_addr,
    output logic [2*DATA_W-1:0]          ram_wdata,
    output logic [1:0]                   ram_we,
    input  logic [2*DATA_W-1:0]          ram_q,
    input  logic                         host_buf,
    input  logic [ADDR_W-1:0]            host_addr,
    input  logic [DATA_W-1:0]            host_wdata,
    input  logic                         host_we,
    output logic [DATA_W-1:0]            host_rdata
);

    logic [ADDR_W-1:0] act_rd_addr;
    logic [ADDR_W-1:0] act_wr_addr;
    logic [DATA_W-1:0] act_wr_data;
    logic              act_we;
    logic              rd;

    always_comb begin
        act_rd_addr = '0;
        act_wr_addr = '0;
        act_wr_data = '0;
        act_we      = 1'b0;
        for (int k = 0; k < NUM_LAYERS; k++) begin
            if (k == int'(cur_layer)) begin
                act_rd_addr = layer_inp_addr[k*ADDR_W +: ADDR_W];
                act_wr_addr = layer_out_addr[k*ADDR_W +: ADDR_W];
                act_wr_data = layer_out_data[k*DATA_W +: DATA_W];
                act_we      = layer_out_we[k];
            end
        end
    end

    assign rd = rd_buf(cur_layer);

    // While busy the read RAM sees only the read address (never written) and
    // the other RAM takes the write port; while idle the host owns host_buf.
    for (genvar r = 0; r < 2; r++) begin : g_ram
        localparam logic R = 1'(r);
        assign ram_addr[r*ADDR_W +: ADDR_W] = busy ? (rd == R ? act_rd_addr : act_wr_addr)
                                                   : (host_buf == R ? host_addr : '0);
        assign ram_wdata[r*DATA_W +: DATA_W] = busy ? (rd == R ? '0 : act_wr_data)
                                                    : (host_buf == R ? host_wdata : '0);
        assign ram_we[r] = busy ? (rd != R && act_we) : (host_buf == R && host_we);
    end

    assign layer_inp_data = rd == RAM1 ? ram_q[2*DATA_W-1:DATA_W] : ram_q[DATA_W-1:0];
    assign host_rdata     = host_buf == RAM0 ? ram_q[DATA_W-1:0] : ram_q[2*DATA_W-1:DATA_W];

endmodule

// File: rtl/layer_sequencer.sv
// layer_sequencer: runs NUM_LAYERS layer engines in order over two ping-pong RAMs.
//   clk, reset        : clock, synchronous active-high reset
//   start             : one-cycle pulse starting a full inference (ignored while busy)
//   busy, done, error : run in progress, end-of-run pulse, sticky watchdog flag
//   cur_layer         : index of the active layer
//   layer_reset/valid : per-layer control, only the active layer leaves reset
//   layer_done        : per-layer completion, only the active layer's is used
//   layer_*_addr/data/we, layer_inp_data : layer RAM ports
//   ram_*             : RAM0/RAM1 ports (1-cycle registered read)
//   host_*            : host access to RAM host_buf while idle
// Optional: define SEQ_WATCHDOG_EN to abort a layer after WATCHDOG_CYCLES RUN
// cycles without done (sets error); otherwise error is tied low.
module layer_sequencer
    import seq_pkg::*;
#(
    parameter int NUM_LAYERS      = 4,
    parameter int ADDR_W          = 11,
    parameter int DATA_W          = 16,
    parameter int WATCHDOG_CYCLES = 1000000
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    output logic                         busy,
    output logic                         done,
    output logic                         error,
    output logic [LAYER_W-1:0]           cur_layer,
    output logic [NUM_LAYERS-1:0]        layer_reset,
    output logic [NUM_LAYERS-1:0]        layer_valid,
    input  logic [NUM_LAYERS-1:0]        layer_done,
    input  logic [NUM_LAYERS*ADDR_W-1:0] layer_inp_addr,
    input  logic [NUM_LAYERS*ADDR_W-1:0] layer_out_addr,
    input  logic [NUM_LAYERS*DATA_W-1:0] layer_out_data,
    input  logic [NUM_LAYERS-1:0]        layer_out_we,
    output logic [DATA_W-1:0]            layer_inp_data,
    output logic [2*ADDR_W-1:0]          ram_addr,
    output logic [2*DATA_W-1:0]          ram_wdata,
    output logic [1:0]                   ram_we,
    input  logic [2*DATA_W-1:0]          ram_q,
    input  logic                         host_buf,
    input  logic [ADDR_W-1:0]            host_addr,
    input  logic [DATA_W-1:0]            host_wdata,
    input  logic                         host_we,
    output logic [DATA_W-1:0]            host_rdata
);

    seq_state_t            state;
    logic [NUM_LAYERS-1:0] sel;
    logic                  last;

    assign sel  = {{(NUM_LAYERS-1){1'b0}}, 1'b1} << cur_layer;
    assign last = cur_layer == LAYER_W'(NUM_LAYERS - 1);

`ifdef SEQ_WATCHDOG_EN
    localparam int WD_W = $clog2(WATCHDOG_CYCLES + 1);
    logic [WD_W-1:0] wd_cnt;
`else
    assign error = 1'b0;
`endif

    // An accepted start raises busy first and leaves IDLE on the following
    // cycle, so start->valid and done->next valid are both three cycles.
    // Layer outputs are updated on the edge entering LAUNCH (reset low, valid
    // high) and on the edge leaving RUN (back into reset).
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            cur_layer   <= '0;
            layer_reset <= '1;
            layer_valid <= '0;
`ifdef SEQ_WATCHDOG_EN
            error       <= 1'b0;
            wd_cnt      <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (busy) begin
                        state <= CLEAR;
                    end else if (start) begin
                        busy      <= 1'b1;
                        cur_layer <= '0;
`ifdef SEQ_WATCHDOG_EN
                        error     <= 1'b0;
`endif
                    end
                end
                CLEAR: begin
                    layer_reset <= ~sel;
                    layer_valid <= sel;
                    state       <= LAUNCH;
                end
                LAUNCH: begin
                    state  <= RUN;
`ifdef SEQ_WATCHDOG_EN
                    wd_cnt <= '0;
`endif
                end
                RUN: begin
                    if (|(layer_done & sel)) begin
                        layer_valid <= '0;
                        layer_reset <= '1;
                        state       <= ADVANCE;
                    end
`ifdef SEQ_WATCHDOG_EN
                    else if (wd_cnt == WD_W'(WATCHDOG_CYCLES - 1)) begin
                        layer_valid <= '0;
                        layer_reset <= '1;
                        error       <= 1'b1;
                        done        <= 1'b1;
                        state       <= FINISH;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
`endif
                end
                ADVANCE: begin
                    if (last) begin
                        done  <= 1'b1;
                        state <= FINISH;
                    end else begin
                        cur_layer <= cur_layer + 1'b1;
                        state     <= CLEAR;
                    end
                end
                FINISH: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    seq_ram_router #(
        .NUM_LAYERS(NUM_LAYERS),
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W)
    ) u_router (
        .cur_layer     (cur_layer),
        .busy          (busy),
        .layer_inp_addr(layer_inp_addr),
        .layer_out_addr(layer_out_addr),
        .layer_out_data(layer_out_data),
        .layer_out_we  (layer_out_we),
        .layer_inp_data(layer_inp_data),
        .ram_addr      (ram_addr),
        .ram_wdata     (ram_wdata),
        .ram_we        (ram_we),
        .ram_q         (ram_q),
        .host_buf      (host_buf),
        .host_addr     (host_addr),
        .host_wdata    (host_wdata),
        .host_we       (host_we),
        .host_rdata    (host_rdata)
    );

endmodule

// File: tb/tb_layer_sequencer.sv
// tb_layer_sequencer: directed bench for layer_sequencer with RAM and layer stubs.
module tb_layer_sequencer;

    localparam int NL = 4;
    localparam int AW = 11;
    localparam int DW = 16;
`ifdef SEQ_WATCHDOG_EN
    localparam int WD = 50;
`else
    localparam int WD = 1000000;
`endif

    logic              clk = 1'b0;
    logic              reset, start;
    logic              busy, done, error;
    logic [2:0]        cur_layer;
    logic [NL-1:0]     layer_reset, layer_valid, layer_done, layer_out_we;
    logic [NL*AW-1:0]  layer_inp_addr, layer_out_addr;
    logic [NL*DW-1:0]  layer_out_data;
    logic [DW-1:0]     layer_inp_data;
    logic [2*AW-1:0]   ram_addr;
    logic [2*DW-1:0]   ram_wdata;
    logic [1:0]        ram_we;
    logic [2*DW-1:0]   ram_q;
    logic              host_buf, host_we;
    logic [AW-1:0]     host_addr;
    logic [DW-1:0]     host_wdata, host_rdata;

    always #5 clk = ~clk;

    layer_sequencer #(
        .NUM_LAYERS(NL), .ADDR_W(AW), .DATA_W(DW), .WATCHDOG_CYCLES(WD)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .busy(busy), .done(done), .error(error), .cur_layer(cur_layer),
        .layer_reset(layer_reset), .layer_valid(layer_valid), .layer_done(layer_done),
        .layer_inp_addr(layer_inp_addr), .layer_out_addr(layer_out_addr),
        .layer_out_data(layer_out_data), .layer_out_we(layer_out_we),
        .layer_inp_data(layer_inp_data),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_q(ram_q),
        .host_buf(host_buf), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_we(host_we), .host_rdata(host_rdata)
    );

    // Two activation RAMs with registered read (1-cycle latency).
    logic [DW-1:0] mem0 [0:2047];
    logic [DW-1:0] mem1 [0:2047];
    logic [DW-1:0] q0, q1;
    assign ram_q = {q1, q0};
    always @(posedge clk) begin
        if (ram_we[0]) mem0[ram_addr[AW-1:0]] <= ram_wdata[DW-1:0];
        if (ram_we[1]) mem1[ram_addr[2*AW-1:AW]] <= ram_wdata[2*DW-1:DW];
        q0 <= mem0[ram_addr[AW-1:0]];
        q1 <= mem1[ram_addr[2*AW-1:AW]];
    end

    // Layer stubs: cnt counts cycles out of reset (0 in the LAUNCH cycle).
    // Active layer k reads addr 5, writes 0x0A5C+k to addr 5 at cnt 2, and
    // raises done at cnt>=dly. Layers held in reset drive junk (write 0xDEAD to
    // addr 7, and a spurious done on layer 3) while another layer is mid-run.
    logic [7:0]    cnt [NL];
    logic [7:0]    dly;
    logic [NL-1:0] en;
    logic          any_mid;
    always @(posedge clk)
        for (int k = 0; k < NL; k++)
            cnt[k] <= layer_reset[k] ? 8'd0 : (cnt[k] == 8'hFF ? 8'hFF : cnt[k] + 8'd1);
    always_comb begin
        any_mid        = 1'b0;
        layer_done     = '0;
        layer_out_we   = '0;
        layer_inp_addr = '0;
        layer_out_addr = '0;
        layer_out_data = '0;
        for (int k = 0; k < NL; k++)
            if (!layer_reset[k] && cnt[k] == 8'd3) any_mid = 1'b1;
        for (int k = 0; k < NL; k++) begin
            layer_inp_addr[k*AW +: AW] = layer_reset[k] ? 11'd7 : 11'd5;
            layer_out_addr[k*AW +: AW] = layer_reset[k] ? 11'd7 : 11'd5;
            layer_out_data[k*DW +: DW] = layer_reset[k] ? 16'hDEAD : 16'h0A5C + 16'(k);
            layer_out_we[k] = layer_reset[k] ? any_mid : (cnt[k] == 8'd2);
            layer_done[k]   = layer_reset[k] ? (k == 3 && any_mid) : (en[k] && cnt[k] >= dly);
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor, sampled on the falling edge.
    logic [NL-1:0] vseen, cap_ok;
    int            vrise [NL];
    logic [DW-1:0] cap [NL];
    logic [DW-1:0] snap0, snap1;
    logic          snapped, busy_seen, bfall_seen;
    int            ndone, done_cyc, brise, bfall, viol;
    always @(negedge clk) begin
        for (int k = 0; k < NL; k++) begin
            if (layer_valid[k] && !vseen[k]) begin
                vseen[k] = 1'b1;
                vrise[k] = cyc;
            end
            if (!layer_reset[k] && cnt[k] == 8'd5 && !cap_ok[k]) begin
                cap_ok[k] = 1'b1;
                cap[k]    = layer_inp_data;
            end
        end
        if (vseen[1] && !snapped) begin
            snapped = 1'b1;
            snap0   = mem0[5];
            snap1   = mem1[5];
        end
        if (done) begin
            ndone    = ndone + 1;
            done_cyc = cyc;
        end
        if (busy && !busy_seen) begin
            busy_seen = 1'b1;
            brise     = cyc;
        end
        if (!busy && busy_seen && !bfall_seen) begin
            bfall_seen = 1'b1;
            bfall      = cyc;
        end
        if ($countones(~layer_reset) > 1 || |(layer_valid & layer_reset)) viol = viol + 1;
    end

    int n_chk = 0;
    int n_fail = 0;
    int sc;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        vseen = '0; cap_ok = '0; snapped = 1'b0; busy_seen = 1'b0; bfall_seen = 1'b0;
        ndone = 0; done_cyc = -1; brise = -1; bfall = -1;
        for (int k = 0; k < NL; k++) vrise[k] = -1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        sc    = cyc;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input int lim);
        for (int i = 0; i < lim && ndone == 0; i++) step();
    endtask

    task automatic host_read(input string name, input logic hb, input logic [AW-1:0] a,
                             input logic [DW-1:0] exp);
        host_buf = hb; host_addr = a; host_we = 1'b0;
        step();
        check(name, host_rdata, exp);
    endtask

    typedef struct {
        logic          hb;
        logic [AW-1:0] addr;
        logic [DW-1:0] wd;
        logic          we;
        logic          chk;
        logic [DW-1:0] exp;
    } hv_t;
    hv_t tbl [10];

    logic restarted;

    initial begin
        tbl[0] = '{1'b0, 11'd100, 16'h1234, 1'b1, 1'b0, 16'h0000};
        tbl[1] = '{1'b1, 11'd100, 16'hBEEF, 1'b1, 1'b0, 16'h0000};
        tbl[2] = '{1'b0, 11'd100, 16'h0000, 1'b0, 1'b1, 16'h1234};
        tbl[3] = '{1'b1, 11'd100, 16'h0000, 1'b0, 1'b1, 16'hBEEF};
        tbl[4] = '{1'b0, 11'd5,   16'h1111, 1'b1, 1'b0, 16'h0000};
        tbl[5] = '{1'b0, 11'd5,   16'h0000, 1'b0, 1'b1, 16'h1111};
        tbl[6] = '{1'b1, 11'd5,   16'h0000, 1'b0, 1'b1, 16'h0000};
        tbl[7] = '{1'b1, 11'd0,   16'h00FF, 1'b1, 1'b0, 16'h0000};
        tbl[8] = '{1'b0, 11'd0,   16'h0000, 1'b0, 1'b1, 16'h0000};
        tbl[9] = '{1'b1, 11'd0,   16'h0000, 1'b0, 1'b1, 16'h00FF};
        for (int i = 0; i < 2048; i++) begin
            mem0[i] = '0;
            mem1[i] = '0;
        end
        viol = 0;
        clear_mon();
        reset = 1'b1; start = 1'b0; dly = 8'd10; en = '1;
        host_buf = 1'b0; host_addr = '0; host_wdata = '0; host_we = 1'b0;
        repeat (3) step();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_cur_layer", cur_layer, 0);
        check("rst_layer_reset", layer_reset, 4'hF);
        check("rst_layer_valid", layer_valid, 0);
        reset = 1'b0;
        step();

        // Host port while idle.
        for (int i = 0; i < 10; i++) begin
            host_buf = tbl[i].hb; host_addr = tbl[i].addr;
            host_wdata = tbl[i].wd; host_we = tbl[i].we;
            step();
            if (tbl[i].chk) check($sformatf("host_vec%0d", i), host_rdata, tbl[i].exp);
        end
        host_we = 1'b0;

        // Full run; host write attempted while busy, second start during layer 2.
        clear_mon();
        viol = 0;
        restarted = 1'b0;
        pulse_start();
        host_buf = 1'b0; host_addr = 11'd100; host_wdata = 16'hFFFF; host_we = 1'b1;
        for (int i = 0; i < 3000 && ndone == 0; i++) begin
            step();
            start = 1'b0;
            if (vseen[3]) host_we = 1'b0;
            if (vseen[2] && !restarted && cyc >= vrise[2] + 4) begin
                start     = 1'b1;
                restarted = 1'b1;
            end
        end
        start = 1'b0;
        host_we = 1'b0;
        repeat (20) step();
        check("run_done_count", ndone, 1);
        check("run_valid0_lat", vrise[0], sc + 3);
        for (int k = 1; k < NL; k++)
            check($sformatf("run_valid%0d_lat", k), vrise[k], vrise[k-1] + 13);
        check("run_done_cycle", done_cyc, vrise[3] + 12);
        check("run_busy_rise", brise, sc + 1);
        check("run_busy_fall", bfall, done_cyc + 1);
        check("run_one_active", viol, 0);
        check("run_error", error, 0);
        check("l0_read_ram0", cap[0], 16'h1111);
        check("l1_read_ram1", cap[1], 16'h0A5C);
        check("l2_read_ram0", cap[2], 16'h0A5D);
        check("l3_read_ram1", cap[3], 16'h0A5E);
        check("after_l0_ram0_addr5", snap0, 16'h1111);
        check("after_l0_ram1_addr5", snap1, 16'h0A5C);
        host_read("busy_host_we_ignored", 1'b0, 11'd100, 16'h1234);
        host_read("final_ram0_addr5", 1'b0, 11'd5, 16'h0A5F);
        host_read("final_ram1_addr5", 1'b1, 11'd5, 16'h0A5E);
        host_read("junk_ram0_addr7", 1'b0, 11'd7, 16'h0000);
        host_read("junk_ram1_addr7", 1'b1, 11'd7, 16'h0000);

        // Reset in RUN of layer 1, then a fresh run.
        clear_mon();
        pulse_start();
        for (int i = 0; i < 200 && !vseen[1]; i++) step();
        check("rr_reached_l1", vseen[1], 1);
        repeat (2) step();
        reset = 1'b1;
        step();
        check("rr_layer_reset", layer_reset, 4'hF);
        check("rr_layer_valid", layer_valid, 0);
        check("rr_busy", busy, 0);
        check("rr_cur_layer", cur_layer, 0);
        reset = 1'b0;
        step();
        clear_mon();
        pulse_start();
        wait_done(3000);
        check("rr_restart_valid0", vrise[0], sc + 3);
        check("rr_restart_done", ndone, 1);
        repeat (3) step();

        // done already high in LAUNCH: acted on in the first RUN cycle.
        dly = 8'd0;
        clear_mon();
        pulse_start();
        wait_done(3000);
        check("z_valid0_lat", vrise[0], sc + 3);
        for (int k = 1; k < NL; k++)
            check($sformatf("z_valid%0d_lat", k), vrise[k], vrise[k-1] + 4);
        check("z_done_cycle", done_cyc, vrise[3] + 3);
        dly = 8'd10;
        repeat (3) step();

`ifdef SEQ_WATCHDOG_EN
        // Layer 2 never finishes: watchdog aborts after WD RUN cycles.
        en = 4'b1011;
        clear_mon();
        pulse_start();
        wait_done(3000);
        repeat (5) step();
        check("wd_error", error, 1);
        check("wd_done_count", ndone, 1);
        check("wd_done_cycle", done_cyc, vrise[2] + WD + 1);
        check("wd_l3_never", vseen[3], 0);
        check("wd_resets_high", layer_reset, 4'hF);
        en = '1;
        clear_mon();
        pulse_start();
        check("wd_error_cleared", error, 0);
        wait_done(3000);
        repeat (3) step();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
